jts16_gfx_arb: RTL and testbench
================================

Name: jts16_gfx_arb

Overview:
- Shares one SDRAM graphics-ROM read port among three video layer fetchers: char, scroll and object.
- Sits between the layer engines (char tiles, scroll tilemaps, sprite engine) inside the video block and the SDRAM bank controller.
- Each requester keeps a one-entry 32-bit cache, so repeated fetches of the same address return without SDRAM traffic.
- Cache misses are served round-robin, one outstanding SDRAM transaction at a time.

Parameters:
- AW, 22, SDRAM word-address width.
- CHAR_AW, 13, char requester address width.
- SCR_AW, 17, scroll requester address width.
- OBJ_AW, 19, object requester address width.
- CHAR_OFFSET, 22'h00000, SDRAM base word address of char ROM.
- SCR_OFFSET, 22'h08000, SDRAM base word address of scroll ROM.
- OBJ_OFFSET, 22'h40000, SDRAM base word address of object ROM.

Ports:
- clk  in  1  system clock, single domain
- rst  in  1  synchronous reset, active-high
- char_cs  in  1  char fetch request, held until char_ok
- char_addr  in  CHAR_AW  char word address, stable while char_cs high
- char_ok  out  1  char_data valid for the current char_addr
- char_data  out  32  char ROM word
- scr_cs / scr_addr[SCR_AW] / scr_ok / scr_data[32]  same semantics, scroll layer
- obj_cs / obj_addr[OBJ_AW] / obj_ok / obj_data[32]  same semantics, object layer
- sdram_req  out  1  read request to the bank controller
- sdram_addr  out  AW  request word address
- sdram_ack  in  1  controller accepted the request
- data_rdy  in  1  sdram_dout valid, one-cycle pulse
- sdram_dout  in  32  read data

Behaviour:
- Reset values: sdram_req=0, sdram_addr=0, all *_data=0, all cache valid bits=0 (so all *_ok=0), state=IDLE, rr pointer=char.
- Hit logic per requester x: x_ok = x_cs & valid_x & (x_addr == tag_x), combinational from registers; x_data is the registered cache word. Hit latency is 0 cycles.
- Miss for x: x_cs & ~(valid_x & tag match).
- FSM IDLE:
  - If any miss is pending, grant the first missing requester starting at the rr pointer (order char→scr→obj→char).
  - On the next edge: sdram_addr <= zero-extended x_addr + X_OFFSET (mod 2^AW); sdram_req <= 1; latch the granted index and address; go to WAIT_ACK.
- FSM WAIT_ACK: hold sdram_req and sdram_addr. On sdram_ack: sdram_req <= 0, go to WAIT_RDY.
- sdram_ack and data_rdy in the same cycle: treat as done and fill immediately, skipping WAIT_RDY.
- FSM WAIT_RDY: on data_rdy:
  - data_x <= sdram_dout, tag_x <= latched address, valid_x <= 1.
  - rr pointer <= granted index + 1 (wraps obj→char).
  - Go to IDLE.
- Timing: a miss raised in cycle 0 drives sdram_req in cycle 1. A data_rdy in cycle N gives x_ok in cycle N+1 (if x_addr is unchanged), and the next grant can issue sdram_req in cycle N+2.
- Requester changes address or drops cs mid-fetch: the transaction still completes and fills the cache with the latched address. x_ok stays low on tag mismatch and a new miss is arbitrated. No cancellation on the SDRAM side.
- data_rdy while in IDLE or WAIT_ACK: ignored.
- sdram_ack while in IDLE or WAIT_RDY: ignored.
- Reset mid-transaction: state returns to IDLE and valid bits clear. A late data_rdy after reset is ignored.
- A requester can be starved for at most two other transactions.

Optional Feature:
- Macro: JTS16_ARB_CHARPRIO_EN.
- Defined: the char layer always wins arbitration when it has a miss; scr and obj round-robin between themselves. The rr pointer never points at char.
- Undefined: plain three-way round-robin as described above.

Decomposition:
- Package jts16_arb_pkg holds:
  - enum req_idx_t {REQ_CHAR, REQ_SCR, REQ_OBJ}
  - enum arb_st_t {IDLE, WAIT_ACK, WAIT_RDY}
  - localparam NREQ=3
- Sub-module jts16_arb_slot: one-entry cache (tag, valid, data, hit compare).
  - Parameterised by address width and offset.
  - Instantiated three times; it also produces the miss flag and the offset-adjusted SDRAM address.

Test Plan:
- Reset, then char_cs=1, char_addr=13'h0123 → sdram_req=1 with sdram_addr=22'h000123 the next cycle. After ack, data_rdy with dout=32'hDEADBEEF → char_ok=1, char_data=32'hDEADBEEF one cycle later.
- Repeat char_addr=13'h0123 after the fill → char_ok=1 in the same cycle, sdram_req stays 0.
- char, scr, obj all miss simultaneously, each ack/rdy taking 3 cycles → grant order char, scr, obj. scr_addr=17'h00010 appears as sdram_addr=22'h008010.
- char_addr changes from 13'h0001 to 13'h0002 during WAIT_RDY → cache fills with tag 13'h0001, char_ok stays 0, second request issued for 22'h000002.
- sdram_ack and data_rdy in the same cycle → fill completes, FSM back in IDLE the next cycle.
- rst asserted during WAIT_RDY, then data_rdy pulses → all *_ok=0, sdram_req=0, cache is not written.
- With JTS16_ARB_CHARPRIO_EN: continuous char misses plus a scr miss → char is always granted first, and scr is served only in the idle gaps between char misses.

Source files
------------

// File: rtl/jts16_arb_pkg.sv
// rtl/jts16_arb_pkg.sv - shared types for the graphics ROM arbiter
package jts16_arb_pkg;

  localparam int NREQ = 3;

  typedef enum logic [1:0] {REQ_CHAR = 2'd0, REQ_SCR = 2'd1, REQ_OBJ = 2'd2} req_idx_t;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_ACK = 2'd1, WAIT_RDY = 2'd2} arb_st_t;

  function automatic req_idx_t req_next(req_idx_t i);
    case (i)
      REQ_CHAR: return REQ_SCR;
      REQ_SCR:  return REQ_OBJ;
      default:  return REQ_CHAR;
    endcase
  endfunction

endpackage

// File: rtl/jts16_arb_slot.sv
// rtl/jts16_arb_slot.sv - one-entry read cache for a single layer requester
module jts16_arb_slot #(
  parameter int              AIW    = 13,
  parameter int              AW     = 22,
  parameter logic [AW-1:0]   OFFSET = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cs,
  input  logic [AIW-1:0]  addr,
  input  logic            grant,
  input  logic            fill,
  input  logic [31:0]     fill_data,
  output logic            ok,
  output logic [31:0]     data,
  output logic            miss,
  output logic [AW-1:0]   sd_addr
);

  logic           valid;
  logic [AIW-1:0] tag;
  logic [AIW-1:0] lat_addr;
  logic           hit;

  assign hit     = valid && (addr == tag);
  assign ok      = cs & hit;
  assign miss    = cs & ~hit;
  assign sd_addr = AW'(addr) + OFFSET;

  // The fill tag is the address captured at grant time, not the live one,
  // so a requester that moves on mid-fetch simply misses again.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      tag      <= '0;
      lat_addr <= '0;
      data     <= '0;
    end else begin
      if (grant) lat_addr <= addr;
      if (fill) begin
        valid <= 1'b1;
        tag   <= lat_addr;
        data  <= fill_data;
      end
    end
  end

endmodule

// File: rtl/jts16_gfx_arb.sv
// rtl/jts16_gfx_arb.sv - char/scroll/object graphics ROM arbiter; JTS16_ARB_CHARPRIO_EN gives char fixed priority
module jts16_gfx_arb
  import jts16_arb_pkg::*;
#(
  parameter int            AW          = 22,
  parameter int            CHAR_AW     = 13,
  parameter int            SCR_AW      = 17,
  parameter int            OBJ_AW      = 19,
  parameter logic [AW-1:0] CHAR_OFFSET = 22'h00000,
  parameter logic [AW-1:0] SCR_OFFSET  = 22'h08000,
  parameter logic [AW-1:0] OBJ_OFFSET  = 22'h40000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               char_cs,
  input  logic [CHAR_AW-1:0] char_addr,
  output logic               char_ok,
  output logic [31:0]        char_data,
  input  logic               scr_cs,
  input  logic [SCR_AW-1:0]  scr_addr,
  output logic               scr_ok,
  output logic [31:0]        scr_data,
  input  logic               obj_cs,
  input  logic [OBJ_AW-1:0]  obj_addr,
  output logic               obj_ok,
  output logic [31:0]        obj_data,
  output logic               sdram_req,
  output logic [AW-1:0]      sdram_addr,
  input  logic               sdram_ack,
  input  logic               data_rdy,
  input  logic [31:0]        sdram_dout
);

`ifdef JTS16_ARB_CHARPRIO_EN
  localparam req_idx_t RR_INIT = REQ_SCR;
`else
  localparam req_idx_t RR_INIT = REQ_CHAR;
`endif

  arb_st_t       st, st_nx;
  req_idx_t      gnt, gnt_nx, rr, rr_nx, pick;
  logic          pick_vld;
  logic          req_nx;
  logic [AW-1:0] addr_nx;
  logic          fill_en;
  logic [NREQ-1:0] miss, grant_v, fill_v;
  logic [AW-1:0]   slot_addr [NREQ];

  jts16_arb_slot #(.AIW(CHAR_AW), .AW(AW), .OFFSET(CHAR_OFFSET)) u_char (
    .clk(clk), .rst(rst), .cs(char_cs), .addr(char_addr),
    .grant(grant_v[REQ_CHAR]), .fill(fill_v[REQ_CHAR]), .fill_data(sdram_dout),
    .ok(char_ok), .data(char_data), .miss(miss[REQ_CHAR]), .sd_addr(slot_addr[REQ_CHAR])
  );

  jts16_arb_slot #(.AIW(SCR_AW), .AW(AW), .OFFSET(SCR_OFFSET)) u_scr (
    .clk(clk), .rst(rst), .cs(scr_cs), .addr(scr_addr),
    .grant(grant_v[REQ_SCR]), .fill(fill_v[REQ_SCR]), .fill_data(sdram_dout),
    .ok(scr_ok), .data(scr_data), .miss(miss[REQ_SCR]), .sd_addr(slot_addr[REQ_SCR])
  );

  jts16_arb_slot #(.AIW(OBJ_AW), .AW(AW), .OFFSET(OBJ_OFFSET)) u_obj (
    .clk(clk), .rst(rst), .cs(obj_cs), .addr(obj_addr),
    .grant(grant_v[REQ_OBJ]), .fill(fill_v[REQ_OBJ]), .fill_data(sdram_dout),
    .ok(obj_ok), .data(obj_data), .miss(miss[REQ_OBJ]), .sd_addr(slot_addr[REQ_OBJ])
  );

`ifdef JTS16_ARB_CHARPRIO_EN
  req_idx_t rr_other;

  // Char pre-empts; rr only ever alternates between scroll and object.
  always_comb begin
    rr_other = (rr == REQ_SCR) ? REQ_OBJ : REQ_SCR;
    pick     = rr;
    pick_vld = |miss;
    if (miss[REQ_CHAR])   pick = REQ_CHAR;
    else if (miss[rr])    pick = rr;
    else if (miss[rr_other]) pick = rr_other;
  end
`else
  req_idx_t c1, c2;

  // Lowest-priority candidate is assigned first so the rr pointer wins ties.
  always_comb begin
    c1       = req_next(rr);
    c2       = req_next(c1);
    pick     = rr;
    pick_vld = |miss;
    if (miss[c2]) pick = c2;
    if (miss[c1]) pick = c1;
    if (miss[rr]) pick = rr;
  end
`endif

  always_comb begin
    st_nx   = st;
    gnt_nx  = gnt;
    rr_nx   = rr;
    req_nx  = sdram_req;
    addr_nx = sdram_addr;
    grant_v = '0;
    fill_v  = '0;
    fill_en = 1'b0;
    case (st)
      IDLE: begin
        if (pick_vld) begin
          grant_v[pick] = 1'b1;
          gnt_nx        = pick;
          req_nx        = 1'b1;
          addr_nx       = slot_addr[pick];
          st_nx         = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sdram_ack) begin
          req_nx = 1'b0;
          if (data_rdy) begin
            fill_en = 1'b1;
            st_nx   = IDLE;
          end else begin
            st_nx   = WAIT_RDY;
          end
        end
      end
      WAIT_RDY: begin
        if (data_rdy) begin
          fill_en = 1'b1;
          st_nx   = IDLE;
        end
      end
      default: st_nx = IDLE;
    endcase
    if (fill_en) begin
      fill_v[gnt] = 1'b1;
`ifdef JTS16_ARB_CHARPRIO_EN
      if (gnt == REQ_SCR)      rr_nx = REQ_OBJ;
      else if (gnt == REQ_OBJ) rr_nx = REQ_SCR;
`else
      rr_nx = req_next(gnt);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      gnt        <= REQ_CHAR;
      rr         <= RR_INIT;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
    end else begin
      st         <= st_nx;
      gnt        <= gnt_nx;
      rr         <= rr_nx;
      sdram_req  <= req_nx;
      sdram_addr <= addr_nx;
    end
  end

endmodule

// File: tb/tb_jts16_gfx_arb.sv
// tb/tb_jts16_gfx_arb.sv - self-checking bench for jts16_gfx_arb
module tb_jts16_gfx_arb;

`ifdef JTS16_ARB_CHARPRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        char_cs, scr_cs, obj_cs;
  logic [12:0] char_addr;
  logic [16:0] scr_addr;
  logic [18:0] obj_addr;
  logic        char_ok, scr_ok, obj_ok;
  logic [31:0] char_data, scr_data, obj_data;
  logic        sdram_req, sdram_ack, data_rdy;
  logic [21:0] sdram_addr;
  logic [31:0] sdram_dout;

  always #5 clk = ~clk;

  jts16_gfx_arb dut (
    .clk(clk), .rst(rst),
    .char_cs(char_cs), .char_addr(char_addr), .char_ok(char_ok), .char_data(char_data),
    .scr_cs(scr_cs), .scr_addr(scr_addr), .scr_ok(scr_ok), .scr_data(scr_data),
    .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_ok(obj_ok), .obj_data(obj_data),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_rdy(data_rdy), .sdram_dout(sdram_dout)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: per-requester cache contents, a pending
  // transaction record and the fairness pointer.
  localparam logic [21:0] OFS [3] = '{22'h00000, 22'h08000, 22'h40000};
  bit          m_vld [3];
  int unsigned m_tag [3];
  logic [31:0] m_dat [3];
  int          m_rr;
  bit          m_busy, m_acc;
  int          m_gnt;
  int unsigned m_lat;
  logic [21:0] m_addr;

  function automatic int unsigned cur_addr(input int i);
    case (i)
      0:       return int'(char_addr);
      1:       return int'(scr_addr);
      default: return int'(obj_addr);
    endcase
  endfunction

  function automatic bit cur_cs(input int i);
    case (i)
      0:       return char_cs;
      1:       return scr_cs;
      default: return obj_cs;
    endcase
  endfunction

  function automatic bit m_hit(input int i);
    return cur_cs(i) && m_vld[i] && (cur_addr(i) == m_tag[i]);
  endfunction

  function automatic bit m_miss(input int i);
    return cur_cs(i) && !(m_vld[i] && (cur_addr(i) == m_tag[i]));
  endfunction

  task automatic m_fill();
    m_vld[m_gnt] = 1'b1;
    m_tag[m_gnt] = m_lat;
    m_dat[m_gnt] = sdram_dout;
    m_busy       = 1'b0;
    if (PRIO) begin
      if (m_gnt != 0) m_rr = (m_gnt == 1) ? 2 : 1;
    end else begin
      m_rr = (m_gnt + 1) % 3;
    end
  endtask

  task automatic predict();
    int pick;
    pick = -1;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_vld[i] = 1'b0;
        m_tag[i] = 0;
        m_dat[i] = 32'h0;
      end
      m_rr   = PRIO ? 1 : 0;
      m_busy = 1'b0;
      m_acc  = 1'b0;
      m_addr = 22'h0;
    end else if (!m_busy) begin
      if (PRIO) begin
        if (m_miss(0)) pick = 0;
        for (int k = 0; k < 2; k++) begin
          int c;
          c = 1 + ((m_rr - 1 + k) % 2);
          if (pick < 0 && m_miss(c)) pick = c;
        end
      end else begin
        for (int k = 0; k < 3; k++) begin
          int c;
          c = (m_rr + k) % 3;
          if (pick < 0 && m_miss(c)) pick = c;
        end
      end
      if (pick >= 0) begin
        m_busy = 1'b1;
        m_acc  = 1'b0;
        m_gnt  = pick;
        m_lat  = cur_addr(pick);
        m_addr = OFS[pick] + 22'(m_lat);
      end
    end else if (!m_acc) begin
      if (sdram_ack) begin
        if (data_rdy) m_fill();
        else          m_acc = 1'b1;
      end
    end else if (data_rdy) begin
      m_fill();
    end
  endtask

  task automatic tick();
    predict();
    @(posedge clk);
    @(negedge clk);
    check("char_ok", char_ok, m_hit(0));
    check("scr_ok",  scr_ok,  m_hit(1));
    check("obj_ok",  obj_ok,  m_hit(2));
    check("char_data", char_data, m_dat[0]);
    check("scr_data",  scr_data,  m_dat[1]);
    check("obj_data",  obj_data,  m_dat[2]);
    check("sdram_req", sdram_req, m_busy && !m_acc);
    if (sdram_req) check("sdram_addr", sdram_addr, m_addr);
    rst       = 1'b0;
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
  endtask

  task automatic wait_req();
    for (int n = 0; n < 20 && !sdram_req; n++) tick();
    if (!sdram_req) check("req_timeout", sdram_req, 1'b1);
  endtask

  task automatic serve(input string tag, input logic [21:0] exp_addr, input logic [31:0] d);
    wait_req();
    check(tag, sdram_addr, exp_addr);
    tick(); tick();
    sdram_ack = 1'b1; tick();
    tick();
    data_rdy = 1'b1; sdram_dout = d; tick();
  endtask

  initial begin
    rst = 1'b1; char_cs = 0; scr_cs = 0; obj_cs = 0;
    char_addr = '0; scr_addr = '0; obj_addr = '0;
    sdram_ack = 0; data_rdy = 0; sdram_dout = '0;
    tick();
    rst = 1'b1; tick();
    check("rst_req", sdram_req, 1'b0);
    check("rst_addr", sdram_addr, 22'h0);

    // single miss then fill, then same-cycle hit
    char_cs = 1; char_addr = 13'h0123; tick();
    check("t1_req", sdram_req, 1'b1);
    check("t1_addr", sdram_addr, 22'h000123);
    sdram_ack = 1; tick();
    data_rdy = 1; sdram_dout = 32'hDEADBEEF; tick();
    check("t1_ok", char_ok, 1'b1);
    check("t1_data", char_data, 32'hDEADBEEF);
    tick();
    check("t1_hit_ok", char_ok, 1'b1);
    check("t1_hit_req", sdram_req, 1'b0);

    // three simultaneous misses from a fresh reset
    char_cs = 0; rst = 1; tick();
    char_cs = 1; char_addr = 13'h0040; scr_cs = 1; scr_addr = 17'h00010;
    obj_cs = 1; obj_addr = 19'h00005;
    serve("t2_char", 22'h000040, 32'h11111111);
    serve("t2_scr",  22'h008010, 32'h22222222);
    serve("t2_obj",  22'h040005, 32'h33333333);
    tick();
    check("t2_all_ok", {char_ok, scr_ok, obj_ok}, 3'b111);

    // address moves during the data phase
    scr_cs = 0; obj_cs = 0; char_addr = 13'h0001;
    wait_req();
    check("t3_addr1", sdram_addr, 22'h000001);
    sdram_ack = 1; tick();
    char_addr = 13'h0002;
    data_rdy = 1; sdram_dout = 32'hCAFE0001; tick();
    check("t3_ok", char_ok, 1'b0);
    serve("t3_addr2", 22'h000002, 32'hCAFE0002);

    // ack and data together
    char_addr = 13'h0003;
    wait_req();
    sdram_ack = 1; data_rdy = 1; sdram_dout = 32'h0BADF00D; tick();
    check("t4_ok", char_ok, 1'b1);
    check("t4_req", sdram_req, 1'b0);
    char_addr = 13'h0005; tick();
    check("t4_idle", sdram_req, 1'b1);
    sdram_ack = 1; tick();
    data_rdy = 1; tick();

    // reset in the data phase, late data ignored
    char_addr = 13'h0006;
    wait_req();
    sdram_ack = 1; tick();
    char_cs = 0; rst = 1; tick();
    data_rdy = 1; sdram_dout = 32'h55AA55AA; tick();
    check("t5_req", sdram_req, 1'b0);
    check("t5_data", char_data, 32'h0);
    char_cs = 1; tick();
    check("t5_ok", char_ok, 1'b0);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 5) == 0) begin
        char_cs = ($urandom_range(0, 3) != 0);
        char_addr = 13'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 5) == 0) begin
        scr_cs = ($urandom_range(0, 3) != 0);
        scr_addr = 17'h00010 + 17'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 5) == 0) begin
        obj_cs = ($urandom_range(0, 3) != 0);
        obj_addr = 19'h7FFF0 + 19'($urandom_range(0, 3) * 5);
      end
      if (m_busy && !m_acc) begin
        sdram_ack = ($urandom_range(0, 2) == 0);
        data_rdy  = sdram_ack ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      end else if (m_busy) begin
        data_rdy  = ($urandom_range(0, 2) == 0);
        sdram_ack = ($urandom_range(0, 7) == 0);
      end else begin
        sdram_ack = ($urandom_range(0, 15) == 0);
        data_rdy  = ($urandom_range(0, 15) == 0);
      end
      sdram_dout = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
